mult_share_sched: RTL and testbench

- Scheduler that shares one iterative unsigned multiplier datapath between two requesters.
- Arbitrates round-robin between the requesters and sequences the shift-add datapath, processing STEPS multiplier bits per cycle.
- Holds each 2*WIDTH-bit product, tagged with the requester id, until the consumer accepts it.
- Sits between the two issuing pipelines and the downstream writeback stage; replaces per-requester multiplier copies.

---
 rtl/mult_share_sched_pkg.sv | 19 +
 rtl/mult_share_sched_if.sv | 36 +++
 rtl/mult_share_sched_step.sv | 38 +++
 rtl/mult_share_sched.sv | 173 +++++++++++++++++
 tb/tb_mult_share_sched.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_sched_pkg.sv
// Shared types and elaboration helpers for the two-requester shared multiplier.
// Holds the FSM encoding and the iteration-count derivation used by the controller.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned calc_iters(input int unsigned width, input int unsigned steps);
        return width / steps;
    endfunction

    function automatic bit steps_divide(input int unsigned width, input int unsigned steps);
        return (steps != 32'd0) && ((width % steps) == 32'd0);
    endfunction

endpackage

// File: rtl/mult_share_sched_if.sv
// Request/response bundle between the two issuing pipelines, the writeback
// consumer (master side) and the shared multiplier scheduler (slave side).
interface mult_share_sched_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;
    logic                 resp_valid;
    logic                 resp_ready;
    logic                 resp_id;
    logic [2*WIDTH-1:0]   resp_product;
    logic                 busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_product, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_product, busy
    );

endinterface

// File: rtl/mult_share_sched_step.sv
// Combinational block retiring STEPS multiplier bits of a shift-add multiply.
// The per-step carry is kept as an extra MSB so all-ones operands stay exact.
module mult_step_block #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = 8
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic [2*WIDTH-1:0] acc_next
);

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        logic [2*WIDTH-1:0] in_s;
        logic [WIDTH:0]     sum_s;
        logic [2*WIDTH:0]   wide_s;
        logic [2*WIDTH-1:0] out_s;

        if (i == 0) begin : g_first
            assign in_s = acc;
        end else begin : g_chain
            assign in_s = g_step[i-1].out_s;
        end

        // Conditional add of the multiplicand into the upper half, then shift right.
        always_comb begin
            if (in_s[0]) begin
                sum_s = {1'b0, in_s[2*WIDTH-1:WIDTH]} + {1'b0, multiplicand};
            end else begin
                sum_s = {1'b0, in_s[2*WIDTH-1:WIDTH]};
            end
            wide_s = {sum_s, in_s[WIDTH-1:0]};
            out_s  = wide_s[2*WIDTH:1];
        end
    end

    assign acc_next = g_step[STEPS-1].out_s;

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one iterative shift-add multiplier between two
// requesters; holds each tagged product until the writeback consumer takes it.
module mult_share_sched
    import mult_share_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = 8
) (
    input  logic               clk,
    input  logic               reset,
    mult_share_sched_if.slave  bus
);

    localparam int unsigned     ITERS    = calc_iters(WIDTH, STEPS);
    localparam int unsigned     CNT_W    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    if (!steps_divide(WIDTH, STEPS)) begin : g_bad_steps
        $error("mult_share_sched: STEPS must divide WIDTH");
    end

    state_t             state_r;
    state_t             state_next_s;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] step_acc_s;
    logic [WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0] product_r;
    logic               id_r;
    logic               last_grant_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               resp_valid_r;
    logic               busy_r;
    logic               grant_valid_s;
    logic               grant_id_s;
    logic [WIDTH-1:0]   sel_a_s;
    logic [WIDTH-1:0]   sel_b_s;

    mult_step_block #(
        .WIDTH (WIDTH),
        .STEPS (STEPS)
    ) u_step (
        .acc          (acc_r),
        .multiplicand (mcand_r),
        .acc_next     (step_acc_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM outputs: round-robin grant and operand select, only while IDLE and out of reset.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if ((state_r == IDLE) && reset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = ~last_grant_r;
            end else if (bus.req0_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b1;
            end else begin
                grant_valid_s = 1'b0;
                grant_id_s    = 1'b0;
            end
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
        if (grant_id_s) begin
            sel_a_s = bus.req1_a;
            sel_b_s = bus.req1_b;
        end else begin
            sel_a_s = bus.req0_a;
            sel_b_s = bus.req0_b;
        end
    end

    // Datapath registers: operand capture, iteration, product hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r        <= {(2*WIDTH){1'b0}};
            mcand_r      <= {WIDTH{1'b0}};
            product_r    <= {(2*WIDTH){1'b0}};
            id_r         <= 1'b0;
            last_grant_r <= 1'b1;
            cnt_r        <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        mcand_r      <= sel_a_s;
                        acc_r        <= {{WIDTH{1'b0}}, sel_b_s};
                        id_r         <= grant_id_s;
                        last_grant_r <= grant_id_s;
                        cnt_r        <= {CNT_W{1'b0}};
                    end
                end
                BUSY: begin
                    acc_r <= step_acc_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        product_r <= step_acc_s;
                    end
                end
                DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Registered status flags, decoded from the upcoming state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            resp_valid_r <= (state_next_s == DONE);
            busy_r       <= (state_next_s != IDLE);
        end
    end

    assign bus.req0_ready   = grant_valid_s & ~grant_id_s;
    assign bus.req1_ready   = grant_valid_s & grant_id_s;
    assign bus.resp_valid   = resp_valid_r;
    assign bus.resp_id      = id_r;
    assign bus.resp_product = product_r;
    assign bus.busy         = busy_r;

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed and randomised self-checking bench for mult_share_sched.
module tb_mult_share_sched;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mult_share_sched_if #(.WIDTH(32)) bus ();

    mult_share_sched #(.WIDTH(32), .STEPS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.req0_valid = 1'b0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
        bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rv"},   64'(bus.resp_valid), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_prod"}, bus.resp_product, 64'd0);
        chk({tag, "_id"},   64'(bus.resp_id), 64'd0);
        chk({tag, "_rdy0"}, 64'(bus.req0_ready), 64'd0);
        chk({tag, "_rdy1"}, 64'(bus.req1_ready), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_reqs();
        bus.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Waits from the first negedge after accept; lat counts edges since accept.
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!bus.resp_valid && lat < 20) begin
            chk("busy_wait", 64'(bus.busy), 64'd1);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic single_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp_p);
        int lat;
        bus.resp_ready = 1'b1;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        chk("grant_rdy0", 64'(bus.req0_ready), 64'(!id));
        chk("grant_rdy1", 64'(bus.req1_ready), 64'(id));
        @(posedge clk);
        @(negedge clk);
        clear_reqs();
        chk("busy_rdy0", 64'(bus.req0_ready), 64'd0);
        wait_resp(lat);
        chk("latency", 64'(lat), 64'd4);
        chk("busy_done", 64'(bus.busy), 64'd1);
        chk("product", bus.resp_product, exp_p);
        chk("resp_id", 64'(bus.resp_id), 64'(id));
        @(posedge clk);
        @(negedge clk);
        chk("rv_drop", 64'(bus.resp_valid), 64'd0);
        chk("busy_drop", 64'(bus.busy), 64'd0);
    endtask

    initial begin : main
        int got;
        int lat;
        int seen;
        int accepted;
        logic [64:0] exp_q[$];
        logic [64:0] e;
        logic [31:0] a0, b0, a1, b1;

        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        clear_reqs();
        bus.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        single_op(1'b0, 32'd3, 32'd5, 64'd15);
        single_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        single_op(1'b1, 32'd0, 32'h1234_5678, 64'd0);
        single_op(1'b0, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF);
        single_op(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        // Both requesters contending continuously from reset.
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 32'd7;  bus.req0_b = 32'd9;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd11; bus.req1_b = 32'd13;
        bus.resp_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                chk("rr_id", 64'(bus.resp_id), 64'(got % 2));
                chk("rr_prod", bus.resp_product, (got % 2 == 1) ? 64'd143 : 64'd63);
                got++;
            end
        end
        chk("rr_count", 64'(got), 64'd4);
        do_reset();

        // Consumer back-pressure in DONE.
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd100; bus.req0_b = 32'd200;
        @(posedge clk);
        @(negedge clk);
        clear_reqs();
        bus.req1_valid = 1'b1; bus.req1_a = 32'd1; bus.req1_b = 32'd1;
        wait_resp(lat);
        chk("stall_lat", 64'(lat), 64'd4);
        for (int k = 0; k < 10; k++) begin
            chk("stall_rv", 64'(bus.resp_valid), 64'd1);
            chk("stall_prod", bus.resp_product, 64'd20000);
            chk("stall_id", 64'(bus.resp_id), 64'd0);
            chk("stall_rdy", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
            chk("stall_busy", 64'(bus.busy), 64'd1);
            @(negedge clk);
        end
        clear_reqs();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_rv_drop", 64'(bus.resp_valid), 64'd0);
        chk("stall_busy_drop", 64'(bus.busy), 64'd0);

        // Asynchronous reset in the second BUSY cycle aborts the operation.
        bus.req0_valid = 1'b1; bus.req0_a = 32'd2; bus.req0_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        clear_reqs();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        chk("abort_no_resp", 64'(seen), 64'd0);
        bus.req0_valid = 1'b1; bus.req0_a = 32'd6; bus.req0_b = 32'd7;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd4; bus.req1_b = 32'd5;
        #1;
        chk("tie_rdy0", 64'(bus.req0_ready), 64'd1);
        chk("tie_rdy1", 64'(bus.req1_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        clear_reqs();
        wait_resp(lat);
        chk("tie_prod", bus.resp_product, 64'd42);
        chk("tie_id", 64'(bus.resp_id), 64'd0);
        @(posedge clk);

        // Random soak against a scoreboard of accepted operations.
        accepted = 0;
        for (int cyc = 0; cyc < 40000 && (accepted < 1000 || exp_q.size() != 0); cyc++) begin
            @(negedge clk);
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            if ($urandom_range(0, 7) == 0) a0 = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) b1 = 32'd0;
            bus.req0_a = a0; bus.req0_b = b0; bus.req1_a = a1; bus.req1_b = b1;
            bus.req0_valid = (accepted < 1000) && ($urandom_range(0, 1) == 1);
            bus.req1_valid = (accepted < 1000) && ($urandom_range(0, 1) == 1);
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.req0_valid && bus.req0_ready) begin
                exp_q.push_back({1'b0, {32'd0, a0} * {32'd0, b0}});
                accepted++;
            end
            if (bus.req1_valid && bus.req1_ready) begin
                exp_q.push_back({1'b1, {32'd0, a1} * {32'd0, b1}});
                accepted++;
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_prod", bus.resp_product, e[63:0]);
                    chk("rnd_id", 64'(bus.resp_id), 64'(e[64]));
                end
            end
        end
        chk("rnd_accepted", 64'(accepted), 64'd1000);
        chk("rnd_drained", 64'(exp_q.size()), 64'd0);
        clear_reqs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
